// File: rtl/hdr_csum_arb.sv
// hdr_csum_arb: round-robin arbiter sharing one header checksum engine among
// PORTS header-beat requesters. The granted beat and its checksum sideband
// are registered into a single output stage tagged with the source port.
// Optional feature: define HDR_CSUM_ARB_CHECK_EN to range-check granted
// checksum requests, mask out-of-range ones and count them in err_count.
module hdr_csum_arb #(
    parameter int PORTS           = 4,
    parameter int AVST_DATA_WIDTH = 600,
    parameter int AVST_ADDR_WIDTH = 9,
    parameter int CSUM_DATA_WIDTH = 160,
    parameter int PORT_WIDTH      = $clog2(PORTS)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [PORTS*AVST_DATA_WIDTH-1:0]   s_data,
    input  logic [PORTS-1:0]                   s_valid,
    output logic [PORTS-1:0]                   s_ready,
    input  logic [PORTS-1:0]                   s_csum_enable,
    input  logic [PORTS*AVST_ADDR_WIDTH-1:0]   s_csum_start,
    input  logic [PORTS*AVST_ADDR_WIDTH-1:0]   s_csum_offset,
    output logic [AVST_DATA_WIDTH-1:0]         m_data,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic                               m_csum_enable,
    output logic [AVST_ADDR_WIDTH-1:0]         m_csum_start,
    output logic [AVST_ADDR_WIDTH-1:0]         m_csum_offset,
    output logic [PORT_WIDTH-1:0]              m_port,
    output logic [15:0]                        err_count
);

    // Round-robin pointer: the most recently granted port.
    logic [PORT_WIDTH-1:0]      last_grant;

    // The output stage can take a new beat when empty or being drained.
    logic                       load;

    // Arbitration result for the current cycle.
    logic                       found;
    logic [PORT_WIDTH-1:0]      winner;

    // Winner's beat and sideband, selected out of the packed input buses.
    logic [AVST_DATA_WIDTH-1:0] sel_data;
    logic                       sel_enable;
    logic [AVST_ADDR_WIDTH-1:0] sel_start;
    logic [AVST_ADDR_WIDTH-1:0] sel_offset;

    // Enable value actually registered (masked when the check rejects it).
    logic                       fwd_enable;

    assign load = !m_valid || m_ready;

    // Scan ports starting just after last_grant; the first valid port wins.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 1; k <= PORTS; k++) begin
            idx = (int'(last_grant) + k) % PORTS;
            if (!found && s_valid[idx]) begin
                found  = 1'b1;
                winner = PORT_WIDTH'(idx);
            end
        end
    end

    // Accept goes only to the winner, only when the output stage can load.
    always_comb begin
        s_ready = '0;
        if (!rst && load && found) begin
            s_ready[winner] = 1'b1;
        end
    end

    // Pull the winner's slice out of each packed input bus.
    always_comb begin
        sel_data   = s_data[int'(winner)*AVST_DATA_WIDTH +: AVST_DATA_WIDTH];
        sel_enable = s_csum_enable[winner];
        sel_start  = s_csum_start[int'(winner)*AVST_ADDR_WIDTH +: AVST_ADDR_WIDTH];
        sel_offset = s_csum_offset[int'(winner)*AVST_ADDR_WIDTH +: AVST_ADDR_WIDTH];
    end

`ifdef HDR_CSUM_ARB_CHECK_EN
    // Summed region or 16-bit result field extends beyond the header beat.
    logic        out_of_range;
    logic [31:0] start_end;
    logic [31:0] offset_end;

    // Range check on the selected request, widened to avoid overflow.
    always_comb begin
        start_end    = 32'(sel_start) + 32'(CSUM_DATA_WIDTH);
        offset_end   = (32'(sel_offset) + 32'd2) << 3;
        out_of_range = (start_end > 32'(AVST_DATA_WIDTH)) ||
                       (offset_end > 32'(AVST_DATA_WIDTH));
    end

    assign fwd_enable = sel_enable && !out_of_range;

    // Count masked requests at the same edge they are registered, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (load && found && sel_enable && out_of_range) begin
            if (err_count != 16'hFFFF) begin
                err_count <= err_count + 16'd1;
            end
        end
    end
`else
    assign fwd_enable = sel_enable;
    assign err_count  = '0;
`endif

    // Output stage and pointer: load the winner, drain to empty, or hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid       <= 1'b0;
            m_data        <= '0;
            m_csum_enable <= 1'b0;
            m_csum_start  <= '0;
            m_csum_offset <= '0;
            m_port        <= '0;
            last_grant    <= PORT_WIDTH'(PORTS - 1);
        end else if (load) begin
            if (found) begin
                m_valid       <= 1'b1;
                m_data        <= sel_data;
                m_csum_enable <= fwd_enable;
                m_csum_start  <= sel_start;
                m_csum_offset <= sel_offset;
                m_port        <= winner;
                last_grant    <= winner;
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hdr_csum_arb.sv
// Testbench for hdr_csum_arb: directed vectors with literal expectations plus
// a behavioural model compared against the DUT every cycle.
module tb_hdr_csum_arb;

   localparam int P  = 4;
   localparam int W  = 600;
   localparam int AW = 9;
   localparam int CW = 160;
   localparam int PW = 2;

   logic              clk;
   logic              rst;
   logic [P*W-1:0]    s_data;
   logic [P-1:0]      s_valid;
   logic [P-1:0]      s_ready;
   logic [P-1:0]      s_csum_enable;
   logic [P*AW-1:0]   s_csum_start;
   logic [P*AW-1:0]   s_csum_offset;
   logic [W-1:0]      m_data;
   logic              m_valid;
   logic              m_ready;
   logic              m_csum_enable;
   logic [AW-1:0]     m_csum_start;
   logic [AW-1:0]     m_csum_offset;
   logic [PW-1:0]     m_port;
   logic [15:0]       err_count;

   logic [W-1:0]      in_data  [P];
   logic [AW-1:0]     in_start [P];
   logic [AW-1:0]     in_off   [P];

   int                n_checks;
   int                n_errors;
   logic              cmp_on;

   // model state
   logic              exp_valid;
   logic [W-1:0]      exp_data;
   logic              exp_en;
   logic [AW-1:0]     exp_start;
   logic [AW-1:0]     exp_off;
   int                exp_port;
   int                exp_lg;
   int                exp_err;

   logic [W-1:0]      held_data;

   hdr_csum_arb #(
      .PORTS(P), .AVST_DATA_WIDTH(W), .AVST_ADDR_WIDTH(AW),
      .CSUM_DATA_WIDTH(CW), .PORT_WIDTH(PW)
   ) dut (
      .clk(clk), .rst(rst),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .s_csum_enable(s_csum_enable), .s_csum_start(s_csum_start),
      .s_csum_offset(s_csum_offset),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .m_csum_enable(m_csum_enable), .m_csum_start(m_csum_start),
      .m_csum_offset(m_csum_offset), .m_port(m_port), .err_count(err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // pack per-port stimulus arrays onto the DUT buses
   always_comb begin
      s_data        = '0;
      s_csum_start  = '0;
      s_csum_offset = '0;
      for (int i = 0; i < P; i++) begin
         s_data[i*W +: W]         = in_data[i];
         s_csum_start[i*AW +: AW] = in_start[i];
         s_csum_offset[i*AW +: AW] = in_off[i];
      end
   end

   function automatic logic [W-1:0] make_data(input int p, input int tag);
      logic [W-1:0] d;
      d = '0;
      d[7:0]     = 8'(tag);
      d[307:300] = 8'(tag ^ 8'h5A);
      d[599:592] = 8'(p + 1);
      return d;
   endfunction

   // first valid port after the model's pointer, -1 when none
   function automatic int model_winner();
      int w;
      w = -1;
      for (int k = 1; k <= P; k++) begin
         if (w < 0 && s_valid[(exp_lg + k) % P]) w = (exp_lg + k) % P;
      end
      return w;
   endfunction

   function automatic logic [P-1:0] exp_ready();
      logic [P-1:0] r;
      int w;
      r = '0;
      w = model_winner();
      if (!rst && (!exp_valid || m_ready) && w >= 0) r[w] = 1'b1;
      return r;
   endfunction

   // behavioural model of the output stage, pointer and error counter
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_valid <= 1'b0;
         exp_data  <= '0;
         exp_en    <= 1'b0;
         exp_start <= '0;
         exp_off   <= '0;
         exp_port  <= 0;
         exp_lg    <= P - 1;
         exp_err   <= 0;
      end else if (!exp_valid || m_ready) begin : mdl
         int w;
         logic bad;
         w = model_winner();
         if (w < 0) begin
            exp_valid <= 1'b0;
         end else begin
            bad = 1'b0;
`ifdef HDR_CSUM_ARB_CHECK_EN
            bad = s_csum_enable[w] &&
                  ((int'(in_start[w]) + CW > W) || ((int'(in_off[w]) + 2) * 8 > W));
`endif
            exp_valid <= 1'b1;
            exp_data  <= in_data[w];
            exp_en    <= s_csum_enable[w] && !bad;
            exp_start <= in_start[w];
            exp_off   <= in_off[w];
            exp_port  <= w;
            exp_lg    <= w;
            if (bad) exp_err <= (exp_err == 65535) ? 65535 : exp_err + 1;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [W-1:0] act,
                              input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input int port, input logic valid,
                                input logic [W-1:0] data, input logic en,
                                input logic [AW-1:0] start, input logic [AW-1:0] off);
      s_valid[port]       = valid;
      in_data[port]       = data;
      s_csum_enable[port] = en;
      in_start[port]      = start;
      in_off[port]        = off;
   endtask

   // per-cycle comparison of every output against the model, before each rising edge
   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (cmp_on) begin
            checkOutput("mdl_s_ready", W'(s_ready), W'(exp_ready()));
            checkOutput("mdl_m_valid", W'(m_valid), W'(exp_valid));
            checkOutput("mdl_m_data", m_data, exp_data);
            checkOutput("mdl_m_port", W'(m_port), W'(exp_port));
            checkOutput("mdl_m_csum_enable", W'(m_csum_enable), W'(exp_en));
            checkOutput("mdl_m_csum_start", W'(m_csum_start), W'(exp_start));
            checkOutput("mdl_m_csum_offset", W'(m_csum_offset), W'(exp_off));
            checkOutput("mdl_err_count", W'(err_count), W'(exp_err));
            if (s_ready != '0 && (s_ready & (s_ready - 1'b1)) != '0) begin
               checkOutput("onehot_s_ready", W'(s_ready), W'(exp_ready()));
            end
         end
      end
   end

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic en1_exp;
      int   err_exp;
      n_checks = 0;
      n_errors = 0;
      cmp_on   = 1'b0;
      rst      = 1'b1;
      m_ready  = 1'b0;
      s_valid  = '0;
      s_csum_enable = '0;
      for (int i = 0; i < P; i++) begin
         in_data[i]  = '0;
         in_start[i] = '0;
         in_off[i]   = '0;
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      cmp_on = 1'b1;
      #3;
      checkOutput("reset_m_valid", W'(m_valid), '0);
      checkOutput("reset_m_data", m_data, '0);
      checkOutput("reset_m_port", W'(m_port), '0);
      checkOutput("reset_err_count", W'(err_count), '0);

      // single requester on port 2
      @(negedge clk);
      applyStimulus(2, 1'b1, W'(8'hAB), 1'b1, 9'd0, 9'd20);
      m_ready = 1'b1;
      #3;
      checkOutput("t1_s_ready", W'(s_ready), W'(4'b0100));
      @(negedge clk);
      s_valid = '0;
      #3;
      checkOutput("t1_m_valid", W'(m_valid), W'(1'b1));
      checkOutput("t1_m_port", W'(m_port), W'(2));
      checkOutput("t1_m_data", m_data, W'(8'hAB));
      checkOutput("t1_m_offset", W'(m_csum_offset), W'(20));

      // all four ports valid: rotation 0,1,2,3,0,1,2,3
      pulse_reset();
      for (int c = 0; c < 8; c++) begin
         if (c > 0) @(negedge clk);
         if (c == 0) begin
            for (int i = 0; i < P; i++)
               applyStimulus(i, 1'b1, make_data(i, 16 + i), 1'b0, 9'd0, 9'd20);
         end
         #3;
         checkOutput("t2_s_ready", W'(s_ready), W'(4'b0001 << (c % 4)));
         if (c > 0) checkOutput("t2_m_port", W'(m_port), W'((c - 1) % 4));
      end
      @(negedge clk);
      s_valid = '0;
      #3;
      checkOutput("t2_m_port_last", W'(m_port), W'(3));

      // ports 1 and 3 with backpressure
      @(negedge clk);
      s_valid = 4'b1010;
      #3;
      checkOutput("t3_first_ready", W'(s_ready), W'(4'b0010));
      @(negedge clk);
      m_ready = 1'b0;
      #3;
      held_data = make_data(1, 17);
      checkOutput("t3_hold_port", W'(m_port), W'(1));
      checkOutput("t3_hold_valid", W'(m_valid), W'(1'b1));
      checkOutput("t3_hold_ready", W'(s_ready), '0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         #3;
         checkOutput("t3_stall_port", W'(m_port), W'(1));
         checkOutput("t3_stall_ready", W'(s_ready), '0);
         checkOutput("t3_stall_data", m_data, held_data);
      end
      @(negedge clk);
      m_ready = 1'b1;
      #3;
      checkOutput("t3_resume_ready", W'(s_ready), W'(4'b1000));
      @(negedge clk);
      #3;
      checkOutput("t3_port3", W'(m_port), W'(3));
      checkOutput("t3_next_ready", W'(s_ready), W'(4'b0010));
      @(negedge clk);
      s_valid = '0;
      #3;
      checkOutput("t3_port1", W'(m_port), W'(1));

      // reset pulse mid-stream
      @(negedge clk);
      s_valid = 4'b1111;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #3;
      checkOutput("t4_rst_valid", W'(m_valid), '0);
      checkOutput("t4_rst_ready", W'(s_ready), '0);
      @(negedge clk);
      rst = 1'b0;
      #3;
      checkOutput("t4_post_ready", W'(s_ready), W'(4'b0001));
      @(negedge clk);
      s_valid = '0;
      #3;
      checkOutput("t4_post_port", W'(m_port), W'(0));

      // checksum range check: port 0 out of range, port 1 in range
`ifdef HDR_CSUM_ARB_CHECK_EN
      en1_exp = 1'b0;
      err_exp = 1;
`else
      en1_exp = 1'b1;
      err_exp = 0;
`endif
      @(negedge clk);
      applyStimulus(0, 1'b1, make_data(0, 99), 1'b1, 9'd480, 9'd10);
      @(negedge clk);
      s_valid[0] = 1'b0;
      applyStimulus(1, 1'b1, make_data(1, 77), 1'b1, 9'd0, 9'd10);
      #3;
      checkOutput("t5_bad_enable", W'(m_csum_enable), W'(en1_exp));
      checkOutput("t5_bad_start", W'(m_csum_start), W'(480));
      checkOutput("t5_bad_err", W'(err_count), W'(err_exp));
      @(negedge clk);
      s_valid = '0;
      #3;
      checkOutput("t5_good_enable", W'(m_csum_enable), W'(1'b1));
      checkOutput("t5_good_port", W'(m_port), W'(1));
      checkOutput("t5_good_err", W'(err_count), W'(err_exp));

`ifdef HDR_CSUM_ARB_CHECK_EN
      // saturation of the error counter
      @(negedge clk);
      applyStimulus(0, 1'b1, make_data(0, 5), 1'b1, 9'd480, 9'd10);
      repeat (70000) @(negedge clk);
      s_valid = '0;
      #3;
      checkOutput("t6_err_saturated", W'(err_count), W'(16'hFFFF));
`endif

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
